// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: fetches square matrices A and B element by element
// from a single-port RAM and emits them as packed {A,A,B,B} column-major
// words with a one-cycle read_en strobe and a downstream hold stall.
// Optional feature macro: MATLOAD_B_TRANSPOSED_EN (B stored column-major).

module matrix_stream_loader #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned NUM_ELEMENTS = 4,
    parameter int unsigned MATRIX_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned A_BASE       = 0,
    parameter int unsigned B_BASE       = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          hold,
    output logic                          mem_rd,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [WIDTH-1:0]              mem_rdata,
    output logic [NUM_ELEMENTS*WIDTH-1:0] rdata,
    output logic                          read_en,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned HALF_WIDTH = MATRIX_WIDTH / 2;
    localparam int unsigned COL_W      = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
    localparam int unsigned ROW_W      = (HALF_WIDTH > 1) ? $clog2(HALF_WIDTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MATRIX_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HALF_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              k;
    logic [1:0]              k_next;
    logic [ROW_W-1:0]        row;
    logic [ROW_W-1:0]        row_next;
    logic [COL_W-1:0]        col;
    logic [COL_W-1:0]        col_next;
    logic                    last_word;
    logic                    emit_fire;
    logic [ADDR_WIDTH-1:0]   fetch_addr;
    logic                    cap_valid;
    logic [1:0]              cap_lane;
    logic [WIDTH-1:0]        lanes [4];

    // RAM address of lane k of the word at row pair rp, column c
    function automatic logic [ADDR_WIDTH-1:0] elem_addr(
        input logic [1:0]       lane,
        input logic [ROW_W-1:0] rp,
        input logic [COL_W-1:0] c
    );
        logic [ADDR_WIDTH-1:0] rr;
        logic [ADDR_WIDTH-1:0] cc;
        logic [ADDR_WIDTH-1:0] mw;
        logic [ADDR_WIDTH-1:0] addr;
        rr = ADDR_WIDTH'({rp, lane[0]});
        cc = ADDR_WIDTH'(c);
        mw = ADDR_WIDTH'(MATRIX_WIDTH);
        if (lane[1] == 1'b0) begin
            addr = ADDR_WIDTH'(A_BASE) + rr * mw + cc;
        end else begin
`ifdef MATLOAD_B_TRANSPOSED_EN
            addr = ADDR_WIDTH'(B_BASE) + cc * mw + rr;
`else
            addr = ADDR_WIDTH'(B_BASE) + rr * mw + cc;
`endif
        end
        return addr;
    endfunction

    // Read strobe follows the EMIT state directly so hold stalls in the same cycle
    assign read_en = (state == S_EMIT) && !hold;

    // Next-state, word/lane counter advance and next fetch address
    always_comb begin
        state_next = state;
        k_next     = k;
        row_next   = row;
        col_next   = col;
        last_word  = (row == ROW_LAST) && (col == COL_LAST);
        emit_fire  = (state == S_EMIT) && !hold;
        case (state)
            S_IDLE: begin
                if (start && !done) begin
                    state_next = S_FETCH;
                    k_next     = 2'd0;
                    row_next   = '0;
                    col_next   = '0;
                end
            end
            S_FETCH: begin
                if (k == 2'd3) begin
                    state_next = S_DRAIN;
                    k_next     = 2'd0;
                end else begin
                    k_next = k + 2'd1;
                end
            end
            S_DRAIN: begin
                state_next = S_EMIT;
            end
            S_EMIT: begin
                if (!hold) begin
                    if (last_word) begin
                        state_next = S_IDLE;
                        row_next   = '0;
                        col_next   = '0;
                    end else begin
                        state_next = S_FETCH;
                        if (row == ROW_LAST) begin
                            row_next = '0;
                            col_next = col + COL_W'(1);
                        end else begin
                            row_next = row + ROW_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        fetch_addr = elem_addr(k_next, row_next, col_next);
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            k     <= 2'd0;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_next;
            k     <= k_next;
            row   <= row_next;
            col   <= col_next;
        end
    end

    // Registered RAM request, busy and done, derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_rd <= (state_next == S_FETCH);
            if (state_next == S_FETCH) begin
                mem_addr <= fetch_addr;
            end
            busy <= (state_next != S_IDLE);
            done <= emit_fire && last_word;
        end
    end

    // Capture returning elements into their lanes; pack the word as the last one lands
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid <= 1'b0;
            cap_lane  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                lanes[i] <= '0;
            end
            rdata <= '0;
        end else begin
            cap_valid <= (state == S_FETCH);
            cap_lane  <= k;
            if (cap_valid) begin
                lanes[cap_lane] <= mem_rdata;
            end
            if (state == S_DRAIN) begin
                rdata <= {lanes[0], lanes[1], lanes[2], mem_rdata};
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: RAM[a]=a, cycle-accurate strobe,
// word and done checks across normal, hold, reset-abort and start-ignore runs.

module tb_matrix_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic [31:0] rdata;
    logic        read_en;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ram [256];
    logic [31:0] rd_a [128];
    logic [7:0]  addr_a [128];
    logic        re_a [128];
    logic        done_a [128];
    logic        busy_a [128];
    logic        memrd_a [128];
    int          exp_re [$];
    int          exp_w [$];
    int          exp_done [$];

    matrix_stream_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .hold      (hold),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .read_en   (read_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int w);
        int c;
        int r;
        logic [7:0] a0, a1, b0, b1;
        c  = w / 2;
        r  = (w % 2) * 2;
        a0 = 8'(r * 4 + c);
        a1 = 8'((r + 1) * 4 + c);
`ifdef MATLOAD_B_TRANSPOSED_EN
        b0 = 8'(16 + c * 4 + r);
        b1 = 8'(16 + c * 4 + r + 1);
`else
        b0 = 8'(16 + r * 4 + c);
        b1 = 8'(16 + (r + 1) * 4 + c);
`endif
        return {a0, a1, b0, b1};
    endfunction

    // Runs n cycles from cycle 0, recording outputs sampled mid-cycle
    task automatic run(input int n, input int s0, input int s1, input int s2,
                       input int hlo, input int hhi, input int rc);
        for (int c = 0; c < n; c++) begin
            start = (c == s0) || (c == s1) || (c == s2);
            hold  = (c >= hlo) && (c <= hhi);
            reset = (c == rc);
            @(negedge clk);
            re_a[c]    = read_en;
            done_a[c]  = done;
            busy_a[c]  = busy;
            memrd_a[c] = mem_rd;
            rd_a[c]    = rdata;
            addr_a[c]  = mem_addr;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        hold  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic reset_gap();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Compares recorded strobes, words and done pulses against the expected queues
    task automatic check_stream(input string tag, input int n);
        int oc [$];
        int od [$];
        int oi;
        logic [31:0] ow;
        for (int c = 0; c < n; c++) begin
            if (re_a[c] === 1'b1) oc.push_back(c);
            if (done_a[c] === 1'b1) od.push_back(c);
        end
        chk($sformatf("%s_re_count", tag), 32'(oc.size()), 32'(exp_re.size()));
        for (int i = 0; i < exp_re.size(); i++) begin
            oi = (i < oc.size()) ? oc[i] : -1;
            ow = (oi >= 0) ? rd_a[oi] : 32'hDEADBEEF;
            chk($sformatf("%s_re_cycle%0d", tag, i), 32'(oi), 32'(exp_re[i]));
            chk($sformatf("%s_word%0d", tag, i), ow, exp_word(exp_w[i]));
        end
        chk($sformatf("%s_done_count", tag), 32'(od.size()), 32'(exp_done.size()));
        for (int i = 0; i < exp_done.size(); i++) begin
            oi = (i < od.size()) ? od[i] : -1;
            chk($sformatf("%s_done_cycle%0d", tag, i), 32'(oi), 32'(exp_done[i]));
        end
    endtask

    logic [31:0] w0_const;
    logic [31:0] w1_const;
    logic [31:0] w2_const;

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 8'(a);
`ifdef MATLOAD_B_TRANSPOSED_EN
        w0_const = 32'h00041011;
        w1_const = 32'h080C1213;
        w2_const = 32'h01051415;
`else
        w0_const = 32'h00041014;
        w1_const = 32'h080C181C;
        w2_const = 32'h01051115;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_read_en", 32'(read_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        // Test A: plain load, no hold
        run(52, 0, -1, -1, 1000, -1, -1);
        exp_re.delete(); exp_w.delete(); exp_done.delete();
        for (int i = 0; i < 8; i++) begin exp_re.push_back(6 + 6 * i); exp_w.push_back(i); end
        exp_done.push_back(49);
        check_stream("A", 52);
        chk("A_w0_const", rd_a[6], w0_const);
        chk("A_w1_const", rd_a[12], w1_const);
        chk("A_w2_const", rd_a[18], w2_const);
`ifndef MATLOAD_B_TRANSPOSED_EN
        chk("A_w7_const", rd_a[48], 32'h0B0F1B1F);
`endif
        chk("A_busy_c0", 32'(busy_a[0]), 32'd0);
        chk("A_busy_c1", 32'(busy_a[1]), 32'd1);
        chk("A_busy_c48", 32'(busy_a[48]), 32'd1);
        chk("A_busy_c49", 32'(busy_a[49]), 32'd0);
        chk("A_memrd_c0", 32'(memrd_a[0]), 32'd0);
        for (int c = 1; c <= 4; c++) chk($sformatf("A_memrd_c%0d", c), 32'(memrd_a[c]), 32'd1);
        chk("A_memrd_c5", 32'(memrd_a[5]), 32'd0);
        chk("A_memrd_c6", 32'(memrd_a[6]), 32'd0);
        chk("A_addr_c1", 32'(addr_a[1]), 32'd0);
        chk("A_addr_c2", 32'(addr_a[2]), 32'd4);

        // Test C: hold high in cycles 6..9
        reset_gap();
        run(56, 0, -1, -1, 6, 9, -1);
        exp_re.delete(); exp_w.delete(); exp_done.delete();
        for (int i = 0; i < 8; i++) begin exp_re.push_back(10 + 6 * i); exp_w.push_back(i); end
        exp_done.push_back(53);
        check_stream("C", 56);
        for (int c = 6; c <= 10; c++) chk($sformatf("C_rdata_c%0d", c), rd_a[c], w0_const);
        chk("C_memrd_c8", 32'(memrd_a[8]), 32'd0);

        // Test D: reset in cycle 20, restart in cycle 25
        reset_gap();
        run(80, 0, 25, -1, 1000, -1, 20);
        chk("D_c21_mem_rd", 32'(memrd_a[21]), 32'd0);
        chk("D_c21_mem_addr", 32'(addr_a[21]), 32'd0);
        chk("D_c21_rdata", rd_a[21], 32'd0);
        chk("D_c21_read_en", 32'(re_a[21]), 32'd0);
        chk("D_c21_busy", 32'(busy_a[21]), 32'd0);
        chk("D_c21_done", 32'(done_a[21]), 32'd0);
        exp_re.delete(); exp_w.delete(); exp_done.delete();
        for (int i = 0; i < 3; i++) begin exp_re.push_back(6 + 6 * i); exp_w.push_back(i); end
        for (int i = 0; i < 8; i++) begin exp_re.push_back(31 + 6 * i); exp_w.push_back(i); end
        exp_done.push_back(74);
        check_stream("D", 80);

        // Test E: extra start pulses in cycles 3 and 49 are ignored
        reset_gap();
        run(52, 0, 3, 49, 1000, -1, -1);
        exp_re.delete(); exp_w.delete(); exp_done.delete();
        for (int i = 0; i < 8; i++) begin exp_re.push_back(6 + 6 * i); exp_w.push_back(i); end
        exp_done.push_back(49);
        check_stream("E", 52);
        chk("E_busy_c50", 32'(busy_a[50]), 32'd0);
        chk("E_busy_c51", 32'(busy_a[51]), 32'd0);
        chk("E_memrd_c50", 32'(memrd_a[50]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Producer side of the matrix-multiplier load port. It fetches square matrices A and B element by element from a single-port on-chip RAM. It packs them into `NUM_ELEMENTS`-wide words in the multiplier's column-major {A,A,B,B} order, and drives the packed word with a one-cycle `read_en` strobe. It sits between the operand RAM and the matrix-multiply datapath and adds a downstream `hold` stall.

## Interface
- `WIDTH`, 8, element width in bits
- `NUM_ELEMENTS`, 4, elements per output word; fixed at 4
- `MATRIX_WIDTH`, 4, matrix dimension; must be even
- `ADDR_WIDTH`, 8, RAM address width
- `A_BASE`, 0, RAM address of A[0][0]
- `B_BASE`, 16, RAM address of B[0][0]

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load of both matrices
- `hold`  in  1  downstream stall; defers the emit
- `mem_rd`  out  1  RAM read request
- `mem_addr`  out  ADDR_WIDTH  RAM read address
- `mem_rdata`  in  WIDTH  RAM data; valid exactly one cycle after `mem_rd`
- `rdata`  out  NUM_ELEMENTS*WIDTH  packed operand word
- `read_en`  out  1  one-cycle strobe; `rdata` is valid in this cycle
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse after the last word is emitted

## Operation
- Word count: W = MATRIX_WIDTH*MATRIX_WIDTH/2, which is 8 by default.
- Word index: w = c*(MATRIX_WIDTH/2) + r/2, for r = 0,2,… and c = 0…MATRIX_WIDTH-1. Column is the outer loop.
- Word contents, MSB first: {A[r][c], A[r+1][c], B[r][c], B[r+1][c]}.
  - Element k=0 occupies `rdata[4*WIDTH-1:3*WIDTH]`.
  - Element k=3 occupies `rdata[WIDTH-1:0]`.
- Addresses:
  - A[r][c] is at A_BASE + r*MATRIX_WIDTH + c.
  - B follows the Configuration section.
  - Address arithmetic is modulo 2^ADDR_WIDTH.
- FSM states:
  - IDLE: exits to FETCH when `start`=1.
  - FETCH: 4 cycles. Asserts `mem_rd` with the addresses of k=0..3 in order. Goes to DRAIN.
  - DRAIN: 1 cycle. Captures the last returning element. Goes to EMIT.
  - EMIT:
    - If `hold`=0: drive `read_en`=1 for this cycle. If this was the last word, go to IDLE and pulse `done` next cycle; otherwise go to FETCH for w+1.
    - If `hold`=1: `read_en`=0, stay in EMIT, keep `rdata` stable.
- Elements are captured into an assembly register, at lane k, on the cycle after their request.
- `rdata` holds its last value between strobes.
- `start` is ignored while `busy`=1 and in the `done` cycle.
- `hold` has no effect outside EMIT. No RAM reads are issued while in EMIT.

## Timing
- Reset values: `mem_rd`=0, `mem_addr`=0, `rdata`=0, `read_en`=0, `busy`=0, `done`=0. The FSM goes to IDLE and all counters clear.
- Reset mid-operation aborts immediately with no `done`. Reset wins over a simultaneous `start`.
- Latency, with `start` sampled high in cycle 0 and `hold`=0:
  - `busy` is high from cycle 1 through the last EMIT cycle.
  - `mem_rd` is high in cycles 1–4.
  - The first `read_en` is in cycle 6.
- Each word takes 6 cycles plus the cycles `hold` is high in EMIT.
- Default configuration: the last `read_en` is in cycle 48, and `done` is high in cycle 49 only.
- A new `start` is accepted from cycle 50.

## Configuration
- Macro: `MATLOAD_B_TRANSPOSED_EN`.
- When defined: B is stored column-major, so B[r][c] is at B_BASE + c*MATRIX_WIDTH + r.
- When undefined: B is row-major, so B[r][c] is at B_BASE + r*MATRIX_WIDTH + c.
- A is always row-major. The macro changes no timing and no port.

## Test plan
- Test A uses default parameters, the macro undefined, RAM[a]=a, `start` in cycle 0 and `hold`=0. It requires:
  - Exactly 8 `read_en` pulses, in cycles 6, 12, …, 48, and `done` only in cycle 49.
  - Word 0 = 0x00041014, word 1 = 0x080C181C, word 2 = 0x01051115, word 7 = 0x0B0F1B1F.
- Test B repeats test A's setup with `MATLOAD_B_TRANSPOSED_EN` defined. It requires word 0 = 0x00041011, word 1 = 0x080C1213 and word 2 = 0x01051415.
- Test C uses test A's setup with `hold`=1 in cycles 6–9. It requires the first `read_en` in cycle 10 with `rdata`=0x00041014 stable in cycles 6–10, and `done` in cycle 53.
- Test D uses test A's setup with `reset` in cycle 20. It requires every output to be 0 in cycle 21, no further `read_en` and no `done`. A `start` in cycle 25 must then reproduce test A's sequence shifted by 25 cycles.
- Test E uses test A's setup with `start` also pulsed in cycles 3 and 49. Both pulses are ignored: exactly 8 `read_en` pulses, `done` in cycle 49, and `busy`=0 in cycle 50.
